rv_hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage RV core (F/D/E/M/W).
- Consumes the E-stage branch resolution (RVPCSrcE), load-use and multi-cycle-unit status.
- Produces stall/flush controls for F, D and E.
- Sequences the multi-cycle redirect window needed when instruction fetch has latency > 1.

---
 rtl/rv_hazard_ctrl.sv | 155 +++++++++++++++
 tb/tb_rv_hazard_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV pipeline: load-use bubbles, mul/div wait, multi-cycle fetch redirect.
// Optional performance counters are compiled in when RV_HAZARD_PERF_EN is defined.
module rv_hazard_ctrl #(
    parameter int FETCH_LAT = 1,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RVPCSrcE,
    input  logic             MemReadE,
    input  logic [4:0]       RdE,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic             MdBusyE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             RedirPending,
    output logic [1:0]       StateDbg
`ifdef RV_HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] PerfRedirects,
    output logic [CNT_W-1:0] PerfLwStalls,
    output logic [CNT_W-1:0] PerfMdStalls
`endif
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_REDIR  = 2'd1;
    localparam logic [1:0] ST_MDWAIT = 2'd2;

    localparam logic [2:0] REDIR_INIT = 3'(FETCH_LAT - 1);

    generate
        if (FETCH_LAT < 1 || FETCH_LAT > 8) begin : g_bad_fetch_lat
            $error("rv_hazard_ctrl: FETCH_LAT must be in 1..8");
        end
        if (CNT_W < 1) begin : g_bad_cnt_w
            $error("rv_hazard_ctrl: CNT_W must be at least 1");
        end
    endgenerate

    logic [1:0] state_q, state_d;
    logic [2:0] redir_cnt_q, redir_cnt_d;
    logic       lw_haz;

    // Handshake-free block: every output is a pure function of state_q and this cycle's inputs.
    always_comb begin
        lw_haz       = MemReadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
        state_d      = state_q;
        redir_cnt_d  = redir_cnt_q;
        StallF       = 1'b0;
        StallD       = 1'b0;
        StallE       = 1'b0;
        FlushD       = 1'b0;
        FlushE       = 1'b0;
        RedirPending = 1'b0;

        case (state_q)
            ST_REDIR: begin
                // E holds only bubbles here, so branch/mul-div/load-use inputs are meaningless.
                FlushD       = 1'b1;
                FlushE       = 1'b1;
                RedirPending = 1'b1;
                if (redir_cnt_q <= 3'd1) begin
                    state_d     = ST_RUN;
                    redir_cnt_d = 3'd0;
                end else begin
                    redir_cnt_d = redir_cnt_q - 3'd1;
                end
            end
            default: begin
                // RUN and MDWAIT share the rules; MDWAIT simply re-evaluates them once MdBusyE drops.
                if (MdBusyE) begin
                    StallF  = 1'b1;
                    StallD  = 1'b1;
                    StallE  = 1'b1;
                    state_d = ST_MDWAIT;
                end else if (RVPCSrcE) begin
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                    if (FETCH_LAT > 1) begin
                        state_d     = ST_REDIR;
                        redir_cnt_d = REDIR_INIT;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (lw_haz) begin
                    StallF  = 1'b1;
                    StallD  = 1'b1;
                    FlushE  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_RUN;
                end
            end
        endcase

        if (reset) begin
            StallF       = 1'b0;
            StallD       = 1'b0;
            StallE       = 1'b0;
            FlushD       = 1'b1;
            FlushE       = 1'b1;
            RedirPending = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            redir_cnt_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            redir_cnt_q <= redir_cnt_d;
        end
    end

    assign StateDbg = state_q;

`ifdef RV_HAZARD_PERF_EN
    logic [CNT_W-1:0] perf_redir_q, perf_redir_d;
    logic [CNT_W-1:0] perf_lw_q,    perf_lw_d;
    logic [CNT_W-1:0] perf_md_q,    perf_md_d;
    logic             inc_redir, inc_lw;

    // A load-use bubble is the only case with StallD set while StallE is clear.
    always_comb begin
        inc_redir    = !reset && (state_q != ST_REDIR) && !MdBusyE && RVPCSrcE;
        inc_lw       = StallD && !StallE;
        perf_redir_d = perf_redir_q + {{(CNT_W-1){1'b0}}, inc_redir};
        perf_lw_d    = perf_lw_q    + {{(CNT_W-1){1'b0}}, inc_lw};
        perf_md_d    = perf_md_q    + {{(CNT_W-1){1'b0}}, StallE};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_redir_q <= '0;
            perf_lw_q    <= '0;
            perf_md_q    <= '0;
        end else begin
            perf_redir_q <= perf_redir_d;
            perf_lw_q    <= perf_lw_d;
            perf_md_q    <= perf_md_d;
        end
    end

    assign PerfRedirects = perf_redir_q;
    assign PerfLwStalls  = perf_lw_q;
    assign PerfMdStalls  = perf_md_q;
`endif

endmodule

// File: tb/tb_rv_hazard_ctrl.sv
// Bench for rv_hazard_ctrl: three instances (FETCH_LAT 1, 3, 4) share stimulus and are scored
// against a reference model through an expected queue, plus directed constant checks.
module tb_rv_hazard_ctrl;

  localparam logic [1:0] M_RUN    = 2'd0;
  localparam logic [1:0] M_REDIR  = 2'd1;
  localparam logic [1:0] M_MDWAIT = 2'd2;

  logic clk = 1'b0;
  logic reset;
  logic rpc_e, mem_read_e, md_busy_e;
  logic [4:0] rd_e, rs1_d, rs2_d;

  logic sf1, sd1, se1, fd1, fe1, rp1;
  logic sf3, sd3, se3, fd3, fe3, rp3;
  logic sf4, sd4, se4, fd4, fe4, rp4;
  logic [1:0] st1, st3, st4;
  logic [7:0] obs1, obs3, obs4;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_q[$];
  logic [1:0] m_st[3], m_nst[3];
  logic [2:0] m_cnt[3], m_ncnt[3];
  int lat_of[3] = '{1, 3, 4};

`ifdef RV_HAZARD_PERF_EN
  logic [31:0] pr1, pl1, pm1, pr3, pl3, pm3, pr4, pl4, pm4;
  logic [31:0] pr_base, pm_base;
`endif

  always #5 clk = ~clk;

  // Observed vector: {state[1:0], StallF, StallD, StallE, FlushD, FlushE, RedirPending}
  assign obs1 = {st1, sf1, sd1, se1, fd1, fe1, rp1};
  assign obs3 = {st3, sf3, sd3, se3, fd3, fe3, rp3};
  assign obs4 = {st4, sf4, sd4, se4, fd4, fe4, rp4};

  rv_hazard_ctrl #(.FETCH_LAT(1), .CNT_W(32)) u_lat1 (
    .clk(clk), .reset(reset), .RVPCSrcE(rpc_e), .MemReadE(mem_read_e), .RdE(rd_e),
    .Rs1D(rs1_d), .Rs2D(rs2_d), .MdBusyE(md_busy_e),
    .StallF(sf1), .StallD(sd1), .StallE(se1), .FlushD(fd1), .FlushE(fe1),
    .RedirPending(rp1), .StateDbg(st1)
`ifdef RV_HAZARD_PERF_EN
    , .PerfRedirects(pr1), .PerfLwStalls(pl1), .PerfMdStalls(pm1)
`endif
  );

  rv_hazard_ctrl #(.FETCH_LAT(3), .CNT_W(32)) u_lat3 (
    .clk(clk), .reset(reset), .RVPCSrcE(rpc_e), .MemReadE(mem_read_e), .RdE(rd_e),
    .Rs1D(rs1_d), .Rs2D(rs2_d), .MdBusyE(md_busy_e),
    .StallF(sf3), .StallD(sd3), .StallE(se3), .FlushD(fd3), .FlushE(fe3),
    .RedirPending(rp3), .StateDbg(st3)
`ifdef RV_HAZARD_PERF_EN
    , .PerfRedirects(pr3), .PerfLwStalls(pl3), .PerfMdStalls(pm3)
`endif
  );

  rv_hazard_ctrl #(.FETCH_LAT(4), .CNT_W(32)) u_lat4 (
    .clk(clk), .reset(reset), .RVPCSrcE(rpc_e), .MemReadE(mem_read_e), .RdE(rd_e),
    .Rs1D(rs1_d), .Rs2D(rs2_d), .MdBusyE(md_busy_e),
    .StallF(sf4), .StallD(sd4), .StallE(se4), .FlushD(fd4), .FlushE(fe4),
    .RedirPending(rp4), .StateDbg(st4)
`ifdef RV_HAZARD_PERF_EN
    , .PerfRedirects(pr4), .PerfLwStalls(pl4), .PerfMdStalls(pm4)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model written from the behavioural description.
  function automatic logic [7:0] model(input int lat, input logic [1:0] st, input logic [2:0] cnt,
                                       input logic rst, input logic rpc, input logic mr,
                                       input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                                       input logic md, output logic [1:0] nst, output logic [2:0] ncnt);
    logic lw;
    logic sf, sd, se, fd, fe, rp;
    lw = mr && (rd != 0) && (rd == r1 || rd == r2);
    {sf, sd, se, fd, fe, rp} = 6'b0;
    nst = st;
    ncnt = cnt;
    if (rst) begin
      fd = 1; fe = 1; nst = M_RUN; ncnt = 0;
      return {M_RUN, sf, sd, se, fd, fe, rp};
    end
    if (st == M_REDIR) begin
      fd = 1; fe = 1; rp = 1;
      if (cnt == 1) begin nst = M_RUN; ncnt = 0; end
      else ncnt = cnt - 1;
    end else if (md) begin
      sf = 1; sd = 1; se = 1; nst = M_MDWAIT;
    end else if (rpc) begin
      fd = 1; fe = 1;
      if (lat > 1) begin nst = M_REDIR; ncnt = 3'(lat - 1); end
      else nst = M_RUN;
    end else if (lw) begin
      sf = 1; sd = 1; fe = 1; nst = M_RUN;
    end else begin
      nst = M_RUN;
    end
    return {st, sf, sd, se, fd, fe, rp};
  endfunction

  // One clock: commit model state at the edge, drive inputs, push expectations, compare at negedge.
  task automatic step(input logic rpc, input logic mr, input logic [4:0] rd,
                      input logic [4:0] r1, input logic [4:0] r2, input logic md);
    logic [7:0] act[3];
    logic [1:0] ns;
    logic [2:0] nc;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      m_st[i] = m_nst[i];
      m_cnt[i] = m_ncnt[i];
    end
    #2;
    rpc_e = rpc; mem_read_e = mr; rd_e = rd; rs1_d = r1; rs2_d = r2; md_busy_e = md;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(model(lat_of[i], m_st[i], m_cnt[i], reset, rpc, mr, rd, r1, r2, md, ns, nc));
      m_nst[i] = ns;
      m_ncnt[i] = nc;
    end
    @(negedge clk);
    act[0] = obs1; act[1] = obs3; act[2] = obs4;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("cyc_lat%0d", lat_of[i]), {24'd0, act[i]}, {24'd0, exp_q.pop_front()});
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 5'd0, 5'd0, 5'd0, 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_st[i] = M_RUN; m_nst[i] = M_RUN; m_cnt[i] = 0; m_ncnt[i] = 0;
    end
  endtask

  // MdBusyE must never be raised while a redirect window is open.
  always @(negedge clk) begin
    if (!reset && md_busy_e) chk("md_in_redir", {29'd0, rp1, rp3, rp4}, 32'd0);
  end

  initial begin
    logic rpc_r, mr_r, md_r, any_redir;
    reset = 1'b1;
    rpc_e = 0; mem_read_e = 0; md_busy_e = 0; rd_e = 0; rs1_d = 0; rs2_d = 0;
    model_reset();
    #3;
    chk("rst_lat1", {24'd0, obs1}, 32'h06);
    chk("rst_lat3", {24'd0, obs3}, 32'h06);
    chk("rst_lat4", {24'd0, obs4}, 32'h06);
    @(negedge clk);
    reset = 1'b0;

    // Load-use bubble, then clear; x0 never hazards.
    step(0, 1, 5'd5, 5'd5, 5'd0, 0);  chk("lu_stall", {24'd0, obs1}, 32'h32);
    step(0, 0, 5'd5, 5'd5, 5'd0, 0);  chk("lu_clear", {24'd0, obs1}, 32'h00);
    step(0, 1, 5'd0, 5'd0, 5'd0, 0);  chk("lu_x0", {24'd0, obs1}, 32'h00);
    step(0, 1, 5'd7, 5'd1, 5'd7, 0);  chk("lu_rs2", {24'd0, obs1}, 32'h32);

    // Branch with single-cycle fetch.
    step(1, 0, 5'd0, 5'd0, 5'd0, 0);  chk("br_lat1", {24'd0, obs1}, 32'h06);
    step(0, 0, 5'd0, 5'd0, 5'd0, 0);  chk("br_lat1_after", {24'd0, obs1}, 32'h00);
    idle(4);

    // Redirect window with FETCH_LAT=3; second redirect at cycle 1 ignored.
    step(1, 0, 5'd0, 5'd0, 5'd0, 0);  chk("redir3_c0", {24'd0, obs3}, 32'h06);
    step(1, 0, 5'd0, 5'd0, 5'd0, 0);  chk("redir3_c1", {24'd0, obs3}, 32'h47);
    step(0, 0, 5'd0, 5'd0, 5'd0, 0);  chk("redir3_c2", {24'd0, obs3}, 32'h47);
    step(0, 0, 5'd0, 5'd0, 5'd0, 0);  chk("redir3_c3", {24'd0, obs3}, 32'h00);
    idle(4);

    // Priority: branch beats load-use; mul/div beats branch.
    step(1, 1, 5'd5, 5'd5, 5'd0, 0);  chk("prio_br_lw", {24'd0, obs1}, 32'h06);
    idle(4);
    step(1, 0, 5'd0, 5'd0, 5'd0, 1);  chk("prio_md_br", {24'd0, obs3}, 32'h38);
    idle(2);

`ifdef RV_HAZARD_PERF_EN
    pr_base = pr1;
    pm_base = pm1;
`endif
    // Mul/div wait for four cycles, then a branch in the release cycle.
    step(0, 0, 5'd0, 5'd0, 5'd0, 1);  chk("md_c0", {24'd0, obs1}, 32'h38);
    for (int k = 1; k < 4; k++) begin
      step(0, 0, 5'd0, 5'd0, 5'd0, 1);  chk("md_wait", {24'd0, obs1}, 32'hB8);
    end
    step(1, 0, 5'd0, 5'd0, 5'd0, 0);  chk("md_release_br", {24'd0, obs1}, 32'h86);
    step(0, 0, 5'd0, 5'd0, 5'd0, 0);
`ifdef RV_HAZARD_PERF_EN
    chk("perf_md", pm1 - pm_base, 32'd4);
    chk("perf_redir", pr1 - pr_base, 32'd1);
`endif
    idle(4);

    // Asynchronous reset in the middle of a FETCH_LAT=4 window.
    step(1, 0, 5'd0, 5'd0, 5'd0, 0);
    step(0, 0, 5'd0, 5'd0, 5'd0, 0);  chk("redir4_c1", {24'd0, obs4}, 32'h47);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("rst_mid_redir4", {24'd0, obs4}, 32'h06);
    chk("rst_mid_redir3", {24'd0, obs3}, 32'h06);
    model_reset();
    @(negedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    step(0, 0, 5'd0, 5'd0, 5'd0, 0);  chk("post_rst4", {24'd0, obs4}, 32'h00);
    step(0, 0, 5'd0, 5'd0, 5'd0, 0);  chk("post_rst4_b", {24'd0, obs4}, 32'h00);

    // Random traffic; mul/div only raised while no instance is inside a redirect window.
    for (int k = 0; k < 400; k++) begin
      any_redir = (m_nst[1] == M_REDIR) || (m_nst[2] == M_REDIR);
      rpc_r = ($urandom_range(0, 5) == 0);
      mr_r  = ($urandom_range(0, 1) == 1);
      md_r  = !any_redir && ($urandom_range(0, 6) == 0);
      step(rpc_r, mr_r, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), md_r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
